// File: rtl/dma_mover_pkg.sv
// Shared types and constants for the DMA block-transfer initiator.
package dma_mover_pkg;

  localparam int   ADDR_W    = 22;
  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ACK_WAIT,
    END_WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/dma_mover.sv
// Chains single-byte requests to the DMA engine for copy/fill transfers; 2 cycles per access.
// Requests are held until dma_ack; the next request is registered on ack so it is ready at dma_end.
module dma_mover
  import dma_mover_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [7:0]        fill_byte,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [LEN_W-1:0]  remaining,
  output logic              dma_req,
  output logic              dma_rnw,
  output logic [ADDR_W-1:0] dma_addr,
  output logic [7:0]        dma_wd,
  input  logic [7:0]        dma_rd,
  input  logic              dma_ack,
  input  logic              dma_end
);

  state_t            state, state_d;
  logic [ADDR_W-1:0] src_q, dst_q, addr_q, dst_nx;
  logic [LEN_W-1:0]  rem_q, rem_nx;
  logic              mode_q, req_q, rnw_q, abt_pend, aborted_q;
  logic [7:0]        fill_q, data_q;
  logic              rd_ack, wr_ack, rd_end, stop_wr;

  always_comb begin
    rd_ack  = (state == ACK_WAIT) && dma_ack && rnw_q;
    wr_ack  = (state == ACK_WAIT) && dma_ack && !rnw_q;
    // A registered write pending during END_WAIT in copy mode means a read is completing.
    rd_end  = (state == END_WAIT) && dma_end && (mode_q == MODE_COPY) && req_q && !rnw_q;
    dst_nx  = dst_q + ADDR_W'(1);
    rem_nx  = (rem_q == '0) ? '0 : rem_q - LEN_W'(1);
    stop_wr = (rem_nx == '0) || abort;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:     if (start) state_d = (len == '0) ? DONE : ACK_WAIT;
      ACK_WAIT: if (dma_ack) state_d = END_WAIT;
      END_WAIT: if (dma_end) state_d = req_q ? ACK_WAIT : DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q     <= '0;
      dst_q     <= '0;
      addr_q    <= '0;
      rem_q     <= '0;
      mode_q    <= MODE_COPY;
      fill_q    <= '0;
      data_q    <= '0;
      req_q     <= 1'b0;
      rnw_q     <= 1'b1;
      abt_pend  <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mode_q    <= mode;
            fill_q    <= fill_byte;
            rem_q     <= len;
            src_q     <= src_addr;
            dst_q     <= dst_addr;
            abt_pend  <= 1'b0;
            aborted_q <= 1'b0;
            if (len != '0) begin
              req_q  <= 1'b1;
              rnw_q  <= (mode == MODE_COPY);
              addr_q <= (mode == MODE_COPY) ? src_addr : dst_addr;
            end
          end
        end
        ACK_WAIT: begin
          if (rd_ack) begin
            src_q  <= src_q + ADDR_W'(1);
            rnw_q  <= 1'b0;
            addr_q <= dst_q;
          end else if (wr_ack) begin
            dst_q <= dst_nx;
            rem_q <= rem_nx;
            if (stop_wr) begin
              req_q    <= 1'b0;
              rnw_q    <= 1'b1;
              abt_pend <= (rem_nx != '0);
            end else if (mode_q == MODE_COPY) begin
              rnw_q  <= 1'b1;
              addr_q <= src_q;
            end else begin
              rnw_q  <= 1'b0;
              addr_q <= dst_nx;
            end
          end
        end
        END_WAIT: begin
          if (rd_end) data_q <= dma_rd;
          if (dma_end && !req_q) aborted_q <= abt_pend;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state == ACK_WAIT) || (state == END_WAIT);
  assign done      = (state == DONE);
  assign aborted   = aborted_q;
  assign remaining = rem_q;
  assign dma_req   = req_q;
  assign dma_rnw   = rnw_q;
  assign dma_addr  = addr_q;
  // Read data bypasses straight to the pending write in the read's end cycle.
  assign dma_wd    = (mode_q == MODE_FILL) ? fill_q : (rd_end ? dma_rd : data_q);

endmodule
